task_scheduler: RTL and testbench
=================================

Name: task_scheduler

Overview:
- Upstream neighbour of the instruction fetch stage; decides which channel/thread runs next.
- Latches per-channel wake requests from the I/O channel logic.
- Arbitrates eligible channels round-robin and offers one task at a time to instruction fetch over the next_task ready/ack handshake.
- Tracks which channels are running, so a channel is never offered twice before its task completes.

Parameters:
- NCHAN, 8, number of channels.
- CHAN_W, 3, channel index width; must satisfy 2**CHAN_W == NCHAN.
- THREAD_W, 2, thread number width.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- chan_req  input  NCHAN  per-channel wake request, single-cycle pulse.
- chan_req_thread  input  NCHAN*THREAD_W  thread for each request; channel i uses bits [i*THREAD_W +: THREAD_W].
- task_done  input  1  pulse: the running task on task_done_channel finished.
- task_done_channel  input  CHAN_W  channel finishing.
- next_task_ready  output  1  offer valid.
- next_task_channel  output  CHAN_W  offered channel.
- next_task_thread  output  THREAD_W  offered thread.
- next_task_ack  input  1  instruction fetch accepts offer; sampled at posedge.
- req_overrun  output  1  one-cycle pulse: a request hit a channel already pending.
- busy  output  NCHAN  channel has an accepted, unfinished task.

Behaviour:
- Interface: one clock, clk. Reset reset_n is synchronous and active-low: sampled only at posedge clk, asserted when 0.
- Reset values:
  - next_task_ready=0, next_task_channel=0, next_task_thread=all ones (3).
  - req_overrun=0, busy=0.
  - All pending bits cleared; round-robin pointer=0; state=IDLE.
- Reset mid-offer drops the offer immediately at that edge; ack in the same cycle is ignored.
- Pending capture, at every posedge:
  - chan_req[i]=1 and pending[i]=0: pending[i]<=1, pthread[i]<=thread slice.
  - chan_req[i]=1 and pending[i]=1: request dropped, pthread unchanged, req_overrun pulses the next cycle.
  - This includes a pending channel that is currently being offered; the offer stays stable.
- Eligibility: eligible[i] = pending[i] & ~busy[i].
- State machine (IDLE, OFFER):
  - IDLE: if any channel is eligible, pick the first eligible index searching upward from rr_ptr with wrap NCHAN-1 -> 0. Register channel/thread onto outputs, set next_task_ready=1, go to OFFER.
  - IDLE with nothing eligible: outputs hold their last values, ready=0.
  - OFFER: outputs held stable while ack=0.
  - OFFER, ack=1 at a posedge (transfer): pending[ch]<=0, busy[ch]<=1, rr_ptr<=ch+1 (mod NCHAN), ready<=0, go to IDLE.
- Latency:
  - Request at edge N makes the channel pending after N. Offer is visible after edge N+1.
  - After a transfer at edge T, ready is low for one cycle; the next offer is visible after T+1.
  - Sustained throughput: one task per 2 cycles.
- Completion: task_done=1 clears busy[task_done_channel].
  - task_done for a non-busy channel: ignored.
  - Done and transfer on the same channel in the same edge: transfer wins, busy stays 1.
- Same-edge request and done on one channel: both apply. The channel becomes pending and not busy, so it is eligible the next cycle.
- ack while ready=0: ignored, no state change.

Decomposition:
- Shared package io881_sched_pkg: NCHAN, CHAN_W, THREAD_W, the IDLE/OFFER state encoding, and the reset thread constant (3).
- Instruction fetch uses the same constants.
- One sub-module is natural: rr_arbiter (NCHAN-bit request vector plus start pointer in, one-hot grant and index out, purely combinational).

Test Plan:
- Reset sequence: reset_n low 1 cycle, then high -> ready=0, channel=0, thread=3, busy=0. Values stay unchanged over 3 idle cycles.
- Single request: chan_req[7]=1 with thread 0 -> ready=1, channel=7, thread=0 two edges later. Hold ack=0 for 3 cycles: outputs stable. Ack=1 -> ready drops next cycle, busy[7]=1.
- Round-robin: channels 2, 5 and 0 request at once (threads 1, 2, 3), ack each offer immediately -> offers in order 0, 2, 5, one per 2 cycles. With rr_ptr=3 preloaded by a prior grant on ch2, the order is 5, 0, 2.
- Busy blocking: ch4 accepted (busy), ch4 requests again -> no offer for ch4. task_done with channel 4 -> ch4 offered 2 edges later, busy[4] set again on ack.
- Overrun: ch1 requests with thread 2, then requests again with thread 0 before its transfer -> req_overrun pulses for 1 cycle, and the eventual offer carries thread 2.
- Reset mid-offer: ch6 offered, reset_n=0 in the same cycle ack=1 -> ready=0, busy=0 after the edge, and ch6 is not pending afterwards.

Source files
------------

// File: rtl/io881_sched_pkg.sv
// Shared scheduler constants and state encoding; also used by instruction fetch.
package io881_sched_pkg;

    localparam int unsigned SCHED_NCHAN    = 8;
    localparam int unsigned SCHED_CHAN_W   = 3;
    localparam int unsigned SCHED_THREAD_W = 2;

    // Thread value presented on next_task_thread out of reset.
    localparam logic [SCHED_THREAD_W-1:0] SCHED_THREAD_RST = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_t;

endpackage

// File: rtl/task_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NCHAN  = 8,
    parameter int unsigned CHAN_W = 3
) (
    input  logic [NCHAN-1:0]  req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [NCHAN-1:0]  grant,
    output logic [CHAN_W-1:0] idx,
    output logic              any
);

    logic [CHAN_W-1:0] pos;

    // Scan offsets 0..NCHAN-1 from ptr; index arithmetic wraps because 2**CHAN_W == NCHAN.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            pos = ptr + CHAN_W'(k);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/task_scheduler.sv
// Channel task scheduler: latches wake requests, arbitrates round-robin and
// offers one task at a time to instruction fetch over a ready/ack handshake.
module task_scheduler
    import io881_sched_pkg::*;
#(
    parameter int unsigned NCHAN    = SCHED_NCHAN,
    parameter int unsigned CHAN_W   = SCHED_CHAN_W,
    parameter int unsigned THREAD_W = SCHED_THREAD_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCHAN-1:0]          chan_req,
    input  logic [NCHAN*THREAD_W-1:0] chan_req_thread,
    input  logic                      task_done,
    input  logic [CHAN_W-1:0]         task_done_channel,
    output logic                      next_task_ready,
    output logic [CHAN_W-1:0]         next_task_channel,
    output logic [THREAD_W-1:0]       next_task_thread,
    input  logic                      next_task_ack,
    output logic                      req_overrun,
    output logic [NCHAN-1:0]          busy
);

    sched_state_t state, state_next;

    logic [NCHAN-1:0]    pending;
    logic [THREAD_W-1:0] pthread [NCHAN];
    logic [CHAN_W-1:0]   rr_ptr;

    logic [NCHAN-1:0]    eligible;
    logic [NCHAN-1:0]    grant;
    logic [CHAN_W-1:0]   grant_idx;
    logic                grant_any;

    logic                load_offer;
    logic                xfer;

    assign eligible = pending & ~busy;

    rr_arbiter #(
        .NCHAN  (NCHAN),
        .CHAN_W (CHAN_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes: load an offer from IDLE, complete it on ack.
    always_comb begin
        state_next = state;
        load_offer = 1'b0;
        xfer       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    load_offer = 1'b1;
                    state_next = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (next_task_ack) begin
                    xfer       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pending/busy bookkeeping, round-robin pointer and registered offer outputs.
    // Later NBAs to the same bit win: transfer clears pending after capture and
    // sets busy after a same-edge done, giving transfer priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending           <= '0;
            busy              <= '0;
            rr_ptr            <= '0;
            req_overrun       <= 1'b0;
            next_task_ready   <= 1'b0;
            next_task_channel <= '0;
            next_task_thread  <= THREAD_W'(SCHED_THREAD_RST);
            for (int unsigned i = 0; i < NCHAN; i++) begin
                pthread[i] <= '0;
            end
        end else begin
            req_overrun <= |(chan_req & pending);

            for (int unsigned i = 0; i < NCHAN; i++) begin
                if (chan_req[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    pthread[i] <= chan_req_thread[i*THREAD_W +: THREAD_W];
                end
            end

            if (task_done) begin
                busy[task_done_channel] <= 1'b0;
            end

            if (load_offer) begin
                next_task_ready   <= 1'b1;
                next_task_channel <= grant_idx;
                next_task_thread  <= pthread[grant_idx];
            end

            if (xfer) begin
                pending[next_task_channel] <= 1'b0;
                busy[next_task_channel]    <= 1'b1;
                rr_ptr                     <= next_task_channel + 1'b1;
                next_task_ready            <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_task_scheduler.sv
// Randomized scoreboard bench for task_scheduler against a behavioural model.
module tb_task_scheduler;

    localparam int NCH = 8;
    localparam int CW  = 3;
    localparam int TW  = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    chan_req = '0;
    logic [NCH*TW-1:0] chan_req_thread = '0;
    logic              task_done = 1'b0;
    logic [CW-1:0]     task_done_channel = '0;
    logic              next_task_ready;
    logic [CW-1:0]     next_task_channel;
    logic [TW-1:0]     next_task_thread;
    logic              next_task_ack = 1'b0;
    logic              req_overrun;
    logic [NCH-1:0]    busy;

    task_scheduler #(.NCHAN(NCH), .CHAN_W(CW), .THREAD_W(TW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .chan_req          (chan_req),
        .chan_req_thread   (chan_req_thread),
        .task_done         (task_done),
        .task_done_channel (task_done_channel),
        .next_task_ready   (next_task_ready),
        .next_task_channel (next_task_channel),
        .next_task_thread  (next_task_thread),
        .next_task_ack     (next_task_ack),
        .req_overrun       (req_overrun),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: sets of pending/busy channels plus the current offer.
    bit m_pend [NCH];
    bit m_busy [NCH];
    int m_pthr [NCH];
    int m_ptr;
    bit m_offering;
    int m_chan;
    int m_thr;
    bit m_ovr;
    bit started = 0;
    int exp_q [$];   // expected offers, encoded chan*16+thread

    function automatic logic [NCH-1:0] model_busy();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [NCH*TW-1:0] thr_for(int ch, int t);
        logic [NCH*TW-1:0] v = '0;
        v[ch*TW +: TW] = TW'(t);
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model update at each clock edge, derived from the scheduling rules.
    always @(posedge clk) begin
        started = 1;
        if (!reset_n) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_busy[i] = 0; m_pthr[i] = 0; end
            m_ptr = 0; m_offering = 0; m_chan = 0; m_thr = 3; m_ovr = 0;
        end else begin
            bit xfer;
            int pick;
            xfer = m_offering && next_task_ack;
            pick = -1;
            if (!m_offering) begin
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (pick < 0 && m_pend[c] && !m_busy[c]) pick = c;
                end
            end
            m_ovr = 0;
            for (int i = 0; i < NCH; i++) begin
                if (chan_req[i]) begin
                    if (m_pend[i]) m_ovr = 1;
                    else begin m_pend[i] = 1; m_pthr[i] = int'(chan_req_thread[i*TW +: TW]); end
                end
            end
            if (task_done) m_busy[task_done_channel] = 0;
            if (xfer) begin
                m_pend[m_chan] = 0;
                m_busy[m_chan] = 1;
                m_ptr = (m_chan + 1) % NCH;
                m_offering = 0;
            end
            if (pick >= 0) begin
                m_offering = 1;
                m_chan = pick;
                m_thr = m_pthr[pick];
                exp_q.push_back(pick * 16 + m_thr);
            end
        end
    end

    // Monitor: compare DUT outputs mid-cycle; each new offer pops the scoreboard.
    bit prev_ready = 0;
    always @(negedge clk) begin
        if (started) begin
            chk("ready", int'(next_task_ready), int'(m_offering));
            chk("busy", int'(busy), int'(model_busy()));
            chk("req_overrun", int'(req_overrun), int'(m_ovr));
            chk("channel", int'(next_task_channel), m_chan);
            chk("thread", int'(next_task_thread), m_thr);
            if (next_task_ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("offer_unexpected", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("offer_channel", int'(next_task_channel), e / 16);
                    chk("offer_thread", int'(next_task_thread), e % 16);
                end
            end else if (exp_q.size() != 0) begin
                chk("offer_missing", exp_q.size(), 0);
                exp_q.delete();
            end
            prev_ready = next_task_ready;
        end
    end

    task automatic step(logic [NCH-1:0] req, logic [NCH*TW-1:0] thr,
                        logic dn, int dch, logic ack, logic rstn);
        @(negedge clk);
        chan_req          = req;
        chan_req_thread   = thr;
        task_done         = dn;
        task_done_channel = CW'(dch);
        next_task_ack     = ack;
        reset_n           = rstn;
    endtask

    task automatic idle(int n, logic ack);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 0, ack, 1'b1);
    endtask

    initial begin
        // Reset and quiet cycles.
        step('0, '0, 1'b0, 0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // Single request on ch7, held offer, then accept.
        step(8'h80, thr_for(7, 0), 1'b0, 0, 1'b0, 1'b1);
        idle(4, 1'b0);
        idle(2, 1'b1);
        // Round-robin over ch2/5/0, accepting immediately.
        step(8'h25, thr_for(0, 3) | thr_for(2, 1) | thr_for(5, 2), 1'b0, 0, 1'b0, 1'b1);
        idle(8, 1'b1);
        step('0, '0, 1'b1, 0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 2, 1'b0, 1'b1);
        step('0, '0, 1'b1, 5, 1'b0, 1'b1);
        step('0, '0, 1'b1, 7, 1'b0, 1'b1);
        // Busy blocking on ch4, then release with task_done.
        step(8'h10, thr_for(4, 1), 1'b0, 0, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(8'h10, thr_for(4, 2), 1'b0, 0, 1'b0, 1'b1);
        idle(3, 1'b1);
        step('0, '0, 1'b1, 4, 1'b0, 1'b1);
        idle(4, 1'b1);
        // Overrun on ch1: second request dropped.
        step(8'h02, thr_for(1, 2), 1'b0, 0, 1'b0, 1'b1);
        step(8'h02, thr_for(1, 0), 1'b0, 0, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);
        // Reset while ch6 is offered and acked in the same cycle.
        step(8'h40, thr_for(6, 1), 1'b0, 0, 1'b0, 1'b1);
        idle(2, 1'b0);
        step('0, '0, 1'b0, 0, 1'b1, 1'b0);
        idle(4, 1'b1);
        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0]    r;
            logic [NCH*TW-1:0] t;
            r = '0;
            for (int i = 0; i < NCH; i++) r[i] = ($urandom_range(0, 7) == 0);
            t = NCH*TW'($urandom);
            step(r, t, ($urandom_range(0, 3) == 0), int'($urandom_range(0, NCH-1)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 199) != 0));
        end
        idle(4, 1'b1);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
